// File: rtl/fft_top_if.sv
// Sample/bin bus between the OFDM receive datapath and the 8-point FFT.
// Port shapes match the transmit-side IFFT so the two can be chained back to back.
interface fft_top_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 32
);
  logic                  start;
  logic [N-1:0][W-1:0]   data_in_R_in;
  logic [N-1:0][W-1:0]   data_in_I_in;
  logic [N-1:0][W-1:0]   Real_out;
  logic [N-1:0][W-1:0]   Imag_out;
  logic                  done;
  logic                  busy;

  modport master (
    output start, data_in_R_in, data_in_I_in,
    input  Real_out, Imag_out, done, busy
  );

  modport slave (
    input  start, data_in_R_in, data_in_I_in,
    output Real_out, Imag_out, done, busy
  );
endinterface

// File: rtl/fft_top.sv
// 8-point radix-2 DIT forward FFT: one shared complex butterfly per cycle,
// 12 butterflies per symbol, registered parallel bin outputs with a done pulse.
module fft_top #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 32,
  parameter int unsigned TW = 16
) (
  input logic      clk,
  input logic      rst,
  fft_top_if.slave bus
);

  localparam int unsigned PW   = W + TW;
  localparam int unsigned Frac = TW - 2;
  localparam logic signed [PW-1:0] Rnd = PW'(1 << (Frac - 1));

  typedef enum logic [1:0] {StIdle, StCompute, StOut} state_e;

  state_e              state_q;
  logic [1:0]          stage_q;
  logic [1:0]          bfly_q;
  logic signed [W-1:0] work_re_q [N];
  logic signed [W-1:0] work_im_q [N];
  logic [N-1:0][W-1:0] real_q;
  logic [N-1:0][W-1:0] imag_q;
  logic                done_q;
  logic                busy_q;

  assign bus.Real_out = real_q;
  assign bus.Imag_out = imag_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // Butterfly operand addresses and twiddle index for the current stage/butterfly.
  logic [2:0] idx_a, idx_b;
  logic [1:0] tw_idx;

  always_comb begin
    idx_a  = 3'd0;
    idx_b  = 3'd0;
    tw_idx = 2'd0;
    case (stage_q)
      2'd0: begin
        idx_a  = {bfly_q, 1'b0};
        idx_b  = {bfly_q, 1'b1};
        tw_idx = 2'd0;
      end
      2'd1: begin
        idx_a  = {bfly_q[1], 1'b0, bfly_q[0]};
        idx_b  = {bfly_q[1], 1'b1, bfly_q[0]};
        tw_idx = {bfly_q[0], 1'b0};
      end
      default: begin
        idx_a  = {1'b0, bfly_q};
        idx_b  = {1'b1, bfly_q};
        tw_idx = bfly_q;
      end
    endcase
  end

  logic signed [TW-1:0] tw_re, tw_im;

  always_comb begin
    tw_re = TW'(16384);
    tw_im = TW'(0);
    case (tw_idx)
      2'd0: begin tw_re = TW'(16384);  tw_im = TW'(0);      end
      2'd1: begin tw_re = TW'(11585);  tw_im = -TW'(11585); end
      2'd2: begin tw_re = TW'(0);      tw_im = -TW'(16384); end
      default: begin tw_re = -TW'(11585); tw_im = -TW'(11585); end
    endcase
  end

  // Full-precision products, round-half-up, then truncate back to W bits.
  logic signed [PW-1:0] xr_e, xi_e, wr_e, wi_e, prod_re, prod_im;
  logic signed [W-1:0]  p_re, p_im, a_re, a_im;

  always_comb begin
    xr_e    = {{TW{work_re_q[idx_b][W-1]}}, work_re_q[idx_b]};
    xi_e    = {{TW{work_im_q[idx_b][W-1]}}, work_im_q[idx_b]};
    wr_e    = {{W{tw_re[TW-1]}}, tw_re};
    wi_e    = {{W{tw_im[TW-1]}}, tw_im};
    prod_re = wr_e * xr_e - wi_e * xi_e + Rnd;
    prod_im = wr_e * xi_e + wi_e * xr_e + Rnd;
    p_re    = W'(prod_re >>> Frac);
    p_im    = W'(prod_im >>> Frac);
    a_re    = work_re_q[idx_a];
    a_im    = work_im_q[idx_a];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      stage_q <= 2'd0;
      bfly_q  <= 2'd0;
      real_q  <= '0;
      imag_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < int'(N); k++) begin
        work_re_q[k] <= '0;
        work_im_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            for (int n = 0; n < int'(N); n++) begin
              work_re_q[bitrev3(3'(n))] <= bus.data_in_R_in[n];
              work_im_q[bitrev3(3'(n))] <= bus.data_in_I_in[n];
            end
            stage_q <= 2'd0;
            bfly_q  <= 2'd0;
            busy_q  <= 1'b1;
            state_q <= StCompute;
          end
        end
        StCompute: begin
          work_re_q[idx_a] <= a_re + p_re;
          work_im_q[idx_a] <= a_im + p_im;
          work_re_q[idx_b] <= a_re - p_re;
          work_im_q[idx_b] <= a_im - p_im;
          if (bfly_q == 2'd3) begin
            bfly_q <= 2'd0;
            if (stage_q == 2'd2) begin
              stage_q <= 2'd0;
              state_q <= StOut;
            end else begin
              stage_q <= stage_q + 2'd1;
            end
          end else begin
            bfly_q <= bfly_q + 2'd1;
          end
        end
        StOut: begin
          for (int k = 0; k < int'(N); k++) begin
            real_q[k] <= work_re_q[k];
            imag_q[k] <= work_im_q[k];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
